// File: rtl/gpu_blit_engine.sv
// Clear/scroll engine in front of the character buffer CPU port.
// CPU writes pass through while idle and are held in a one-entry slot while busy.
module gpu_blit_engine #(
    parameter int MAX_COLS = 80,
    parameter int ROWS     = 30,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_80col,
    input  logic              clear_req,
    input  logic              scroll_req,
    input  logic [4:0]        scroll_lines,
    input  logic [DATA_W-1:0] fill_char,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              drop_flag,
    input  logic              drop_clr
);

    typedef enum logic [2:0] {IDLE, START, CLEAR, SCR_RD, SCR_WR, SCR_FILL, FLUSH} state_t;

    state_t            state_q, state_n, eff;
    logic [ADDR_W-1:0] cnt_q, cnt_n, total_q, total_n, shift_q, shift_n, copy_q, copy_n;
    logic              full_q, full_n;
    logic [DATA_W-1:0] fill_q, fill_n;
    logic              slot_full_q, slot_full_n;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_n;
    logic [DATA_W-1:0] slot_data_q, slot_data_n;
    logic              drop_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              mem_we_n, mem_re_n, busy_n, done_n;
    logic [ADDR_W-1:0] cols_a, total_a, shift_a;
    logic [4:0]        lines_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            total_q     <= '0;
            shift_q     <= '0;
            copy_q      <= '0;
            full_q      <= 1'b0;
            fill_q      <= '0;
            slot_full_q <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            drop_flag   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            total_q     <= total_n;
            shift_q     <= shift_n;
            copy_q      <= copy_n;
            full_q      <= full_n;
            fill_q      <= fill_n;
            slot_full_q <= slot_full_n;
            slot_addr_q <= slot_addr_n;
            slot_data_q <= slot_data_n;
            drop_flag   <= drop_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            mem_we      <= mem_we_n;
            mem_re      <= mem_re_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        total_n     = total_q;
        shift_n     = shift_q;
        copy_n      = copy_q;
        full_n      = full_q;
        fill_n      = fill_q;
        slot_full_n = slot_full_q;
        slot_addr_n = slot_addr_q;
        slot_data_n = slot_data_q;
        drop_n      = drop_flag & ~drop_clr;
        mem_addr_n  = '0;
        mem_wdata_n = '0;
        mem_we_n    = 1'b0;
        mem_re_n    = 1'b0;
        done_n      = 1'b0;

        cols_a  = mode_80col ? ADDR_W'(MAX_COLS) : ADDR_W'(MAX_COLS / 2);
        lines_a = (scroll_lines == '0) ? 5'd1 : scroll_lines;
        total_a = cols_a * ADDR_W'(ROWS);
        shift_a = cols_a * ADDR_W'(lines_a);

        // START issues the first access of the chosen command in the same cycle.
        eff = state_q;
        if (state_q == START) eff = full_q ? CLEAR : SCR_RD;

        case (eff)
            IDLE: begin
                mem_we_n    = cpu_we;
                mem_addr_n  = cpu_wr_addr;
                mem_wdata_n = cpu_wr_data;
                if (clear_req || scroll_req) begin
                    state_n = START;
                    full_n  = clear_req || (int'(lines_a) >= ROWS);
                    fill_n  = fill_char;
                    total_n = total_a;
                    shift_n = shift_a;
                    copy_n  = total_a - shift_a;
                    cnt_n   = '0;
                end
            end
            CLEAR: begin
                mem_we_n    = 1'b1;
                mem_addr_n  = cnt_q;
                mem_wdata_n = fill_q;
                if (cnt_q == total_q - ADDR_W'(1)) begin
                    state_n = FLUSH;
                end else begin
                    cnt_n   = cnt_q + ADDR_W'(1);
                    state_n = CLEAR;
                end
            end
            SCR_RD: begin
                mem_re_n   = 1'b1;
                mem_addr_n = cnt_q + shift_q;
                state_n    = SCR_WR;
            end
            SCR_WR: begin
                mem_we_n    = 1'b1;
                mem_addr_n  = cnt_q;
                mem_wdata_n = mem_rdata;
                cnt_n       = cnt_q + ADDR_W'(1);
                state_n     = (cnt_q == copy_q - ADDR_W'(1)) ? SCR_FILL : SCR_RD;
            end
            SCR_FILL: begin
                mem_we_n    = 1'b1;
                mem_addr_n  = cnt_q;
                mem_wdata_n = fill_q;
                if (cnt_q == total_q - ADDR_W'(1)) state_n = FLUSH;
                else cnt_n = cnt_q + ADDR_W'(1);
            end
            FLUSH: begin
                // Stay here while a held write is pending so it is never lost.
                if (slot_full_q) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = slot_addr_q;
                    mem_wdata_n = slot_data_q;
                    slot_full_n = 1'b0;
                end else if (!cpu_we) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_q != IDLE && cpu_we) begin
            if (slot_full_n) drop_n = 1'b1;
            slot_full_n = 1'b1;
            slot_addr_n = cpu_wr_addr;
            slot_data_n = cpu_wr_data;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_gpu_blit_engine.sv
// Self-checking bench for gpu_blit_engine: buffer model, randomized commands,
// expected contents and timing derived from the command rules.
module tb_gpu_blit_engine;
    localparam int MAX_COLS = 80;
    localparam int ROWS     = 30;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              mode_80col = 1'b0, clear_req = 1'b0, scroll_req = 1'b0;
    logic [4:0]        scroll_lines = '0;
    logic [DATA_W-1:0] fill_char = '0;
    logic [ADDR_W-1:0] cpu_wr_addr = '0;
    logic [DATA_W-1:0] cpu_wr_data = '0;
    logic              cpu_we = 1'b0, drop_clr = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we, mem_re, busy, done, drop_flag;

    gpu_blit_engine #(.MAX_COLS(MAX_COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode_80col(mode_80col), .clear_req(clear_req),
        .scroll_req(scroll_req), .scroll_lines(scroll_lines), .fill_char(fill_char),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_we(cpu_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .drop_flag(drop_flag),
        .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    // Character buffer: write on the clock, read data reflects the presented address.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic              load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) mem <= init_mem;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    int checks = 0, errors = 0;
    int exp_nacc;
    int r_nacc, r_first, r_done, r_done_cnt, r_busy_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input bit ramp);
        for (int i = 0; i < DEPTH; i++) init_mem[i] = ramp ? 8'(i) : 8'($urandom);
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // Expected buffer after one command, straight from the clear/scroll rules.
    task automatic build_exp(input bit clr, input bit mode, input logic [4:0] lines,
                             input logic [7:0] fill);
        int cols, total, n, sh;
        cols  = mode ? MAX_COLS : MAX_COLS / 2;
        total = cols * ROWS;
        n     = (lines == 0) ? 1 : int'(lines);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_mem[i];
        if (clr || n >= ROWS) begin
            for (int i = 0; i < total; i++) exp_mem[i] = fill;
            exp_nacc = total;
        end else begin
            sh = n * cols;
            for (int i = 0; i < total - sh; i++) exp_mem[i] = init_mem[i + sh];
            for (int i = total - sh; i < total; i++) exp_mem[i] = fill;
            exp_nacc = 2 * (total - sh) + sh;
        end
    endtask

    // Issue a request at the next edge t, then observe once per cycle (k = cycles after t).
    task automatic run_cmd(input bit clr, input bit scr, input bit mode, input logic [4:0] lines,
                           input logic [7:0] fill, input int wr_k1, input int wr_k2,
                           input int again_k);
        mode_80col = mode; scroll_lines = lines; fill_char = fill;
        clear_req = clr; scroll_req = scr;
        @(posedge clk);
        #1 clear_req = 1'b0; scroll_req = 1'b0;
        r_nacc = 0; r_first = -1; r_done = -1; r_done_cnt = 0; r_busy_bad = 0;
        for (int k = 1; k <= 6000; k++) begin
            @(negedge clk);
            if (mem_we || mem_re) begin
                r_nacc++;
                if (r_first < 0) r_first = k;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done < 0) r_done = k;
            end
            if ((r_done < 0) ? !busy : busy) r_busy_bad++;
            cpu_we = 1'b0;
            if (k == wr_k1) begin cpu_we = 1'b1; cpu_wr_addr = 12'h010; cpu_wr_data = 8'h41; end
            if (k == wr_k2) begin cpu_we = 1'b1; cpu_wr_addr = 12'h011; cpu_wr_data = 8'h42; end
            scroll_req = (k == again_k);
            if (r_done > 0 && k >= r_done + 3) break;
        end
        cpu_we = 1'b0; scroll_req = 1'b0;
    endtask

    task automatic verify(input string tag, input int extra);
        int bad, first_bad;
        bad = 0; first_bad = -1;
        chk({tag, "_accesses"}, r_nacc, exp_nacc + extra);
        chk({tag, "_first_k"}, r_first, 2);
        chk({tag, "_done_k"}, r_done, exp_nacc + extra + 2);
        chk({tag, "_done_pulses"}, r_done_cnt, 1);
        chk({tag, "_busy_profile_bad"}, r_busy_bad, 0);
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        chk({tag, "_mem_mismatches"}, bad, 0);
        if (bad != 0) $display("  first bad addr %0d", first_bad);
    endtask

    initial begin
        logic [4:0] ln;
        logic [7:0] fc;
        bit         md;

        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", {mem_we, mem_re, busy, done, drop_flag, mem_addr, mem_wdata}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        load(1'b0);
        cpu_we = 1'b1; cpu_wr_addr = 12'h123; cpu_wr_data = 8'h5a;
        @(negedge clk);
        cpu_we = 1'b0;
        chk("idle_passthrough", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h123, 8'h5a});
        @(negedge clk);
        chk("idle_we_drops", mem_we, 0);
        chk("idle_mem_written", mem[12'h123], 8'h5a);

        load(1'b0);
        build_exp(1'b1, 1'b0, 5'd0, 8'h20);
        run_cmd(1'b1, 1'b0, 1'b0, 5'd0, 8'h20, -1, -1, -1);
        verify("clear40", 0);

        load(1'b1);
        build_exp(1'b0, 1'b1, 5'd1, 8'h20);
        run_cmd(1'b0, 1'b1, 1'b1, 5'd1, 8'h20, -1, -1, -1);
        verify("scroll80_1", 0);

        load(1'b0);
        md = 1'($urandom); fc = 8'($urandom);
        build_exp(1'b0, md, 5'd1, fc);
        run_cmd(1'b0, 1'b1, md, 5'd0, fc, -1, -1, -1);
        verify("scroll_0_as_1", 0);

        for (int j = 30; j <= 31; j++) begin
            load(1'b0);
            md = 1'($urandom); fc = 8'($urandom);
            build_exp(1'b1, md, 5'd0, fc);
            run_cmd(1'b0, 1'b1, md, 5'(j), fc, -1, -1, -1);
            verify($sformatf("scroll_%0d_as_clear", j), 0);
        end

        for (int j = 0; j < 3; j++) begin
            load(1'b0);
            md = 1'($urandom); fc = 8'($urandom); ln = 5'($urandom_range(1, 29));
            build_exp(1'b0, md, ln, fc);
            run_cmd(1'b0, 1'b1, md, ln, fc, -1, -1, -1);
            verify($sformatf("rand_scroll%0d_n%0d", j, ln), 0);
        end

        load(1'b0);
        build_exp(1'b1, 1'b1, 5'd5, 8'h2e);
        run_cmd(1'b1, 1'b1, 1'b1, 5'd5, 8'h2e, -1, -1, 50);
        verify("clear_beats_scroll", 0);

        load(1'b0);
        build_exp(1'b1, 1'b0, 5'd0, 8'h20);
        exp_mem[12'h011] = 8'h42;
        run_cmd(1'b1, 1'b0, 1'b0, 5'd0, 8'h20, 10, 11, -1);
        verify("held_write", 1);
        chk("drop_flag_set", drop_flag, 1);
        drop_clr = 1'b1;
        @(negedge clk) drop_clr = 1'b0;
        chk("drop_flag_cleared", drop_flag, 0);

        load(1'b0);
        mode_80col = 1'b0; scroll_lines = 5'd3; fill_char = 8'h11; scroll_req = 1'b1;
        @(posedge clk);
        #1 scroll_req = 1'b0;
        repeat (100) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1 chk("reset_mid_scroll", {mem_we, mem_re, busy, done, drop_flag, mem_addr, mem_wdata}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        build_exp(1'b1, 1'b1, 5'd0, 8'h3c);
        run_cmd(1'b1, 1'b0, 1'b1, 5'd0, 8'h3c, -1, -1, -1);
        verify("clear_after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
